// File: rtl/snake_draw_sequencer.sv
// Draw sequencer for the snake render path: walks erase-tail / draw-head /
// draw-food phases and sweeps a BLK x BLK pixel block per phase.
module snake_draw_sequencer #(
  parameter int BLK_LOG2 = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                grow,
  input  logic                food_new,
  output logic [1:0]          sel,
  output logic [BLK_LOG2-1:0] x_off,
  output logic [BLK_LOG2-1:0] y_off,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERASE = 3'd1,
    HEAD  = 3'd2,
    FOOD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_TAIL = 2'd0;
  localparam logic [1:0] SEL_HEAD = 2'd1;
  localparam logic [1:0] SEL_FOOD = 2'd2;

  // Flags captured at acceptance; later input changes cannot reach them.
  typedef struct packed {
    logic food;
  } req_t;

  state_t state;
  req_t   req;
  logic   last_px;

  // Last pixel of a block: both offsets at BLK-1 (all ones).
  assign last_px = (&x_off) & (&y_off);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      req   <= '0;
      sel   <= SEL_TAIL;
      x_off <= '0;
      y_off <= '0;
      plot  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          x_off <= '0;
          y_off <= '0;
          if (start) begin
            req.food <= food_new;
            plot     <= 1'b1;
            busy     <= 1'b1;
            if (grow) begin
              state <= HEAD;
              sel   <= SEL_HEAD;
            end else begin
              state <= ERASE;
              sel   <= SEL_TAIL;
            end
          end
        end

        ERASE, HEAD, FOOD: begin
          // Row-major sweep; at the last pixel both counters overflow to 0,
          // which is exactly the start offset of the following phase.
          x_off <= x_off + 1'b1;
          if (&x_off) y_off <= y_off + 1'b1;
          if (last_px) begin
            case (state)
              ERASE: begin
                state <= HEAD;
                sel   <= SEL_HEAD;
              end
              HEAD: begin
                if (req.food) begin
                  state <= FOOD;
                  sel   <= SEL_FOOD;
                end else begin
                  state <= DONE;
                  plot  <= 1'b0;
                  done  <= 1'b1;
                end
              end
              default: begin
                state <= DONE;
                plot  <= 1'b0;
                done  <= 1'b1;
              end
            endcase
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_draw_sequencer.sv
// Directed bench for snake_draw_sequencer (BLK_LOG2 = 2, 4x4 blocks).
module tb_snake_draw_sequencer;

  logic       clock;
  logic       resetn;
  logic       start;
  logic       grow;
  logic       food_new;
  logic [1:0] sel;
  logic [1:0] x_off;
  logic [1:0] y_off;
  logic       plot;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fails  = 0;

  snake_draw_sequencer #(.BLK_LOG2(2)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .grow     (grow),
    .food_new (food_new),
    .sel      (sel),
    .x_off    (x_off),
    .y_off    (y_off),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] exp_sel);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".plot"}, plot, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".sel"},  sel,  exp_sel);
    chk({tag, ".x"},    x_off, 2'd0);
    chk({tag, ".y"},    y_off, 2'd0);
  endtask

  // Called at the negedge of the first plot cycle; returns at the negedge of
  // the done cycle. Phases run with consecutive sel values from first_sel.
  task automatic expect_seq(input string tag, input int first_sel, input int nph,
                            input bit toggle);
    for (int c = 0; c < nph * 16; c++) begin
      chk({tag, ".plot"}, plot, 1'b1);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".done"}, done, 1'b0);
      chk({tag, ".sel"},  sel,  first_sel + c / 16);
      chk({tag, ".x"},    x_off, (c % 16) % 4);
      chk({tag, ".y"},    y_off, (c % 16) / 4);
      if (toggle && c == 8) begin
        grow     = ~grow;
        food_new = ~food_new;
      end
      @(negedge clock);
    end
    chk({tag, ".done_pulse"}, done, 1'b1);
    chk({tag, ".done_plot"},  plot, 1'b0);
    chk({tag, ".done_busy"},  busy, 1'b1);
    chk({tag, ".done_sel"},   sel,  first_sel + nph - 1);
    chk({tag, ".done_x"},     x_off, 2'd0);
    chk({tag, ".done_y"},     y_off, 2'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    grow     = 1'b0;
    food_new = 1'b0;
    repeat (3) @(negedge clock);
    chk_idle("reset", 2'd0);
    resetn = 1'b1;
    @(negedge clock);
    chk_idle("post_reset", 2'd0);

    // Full three-phase sequence.
    start = 1'b1; grow = 1'b0; food_new = 1'b1;
    @(negedge clock);
    start = 1'b0; food_new = 1'b0;
    expect_seq("full", 0, 3, 1'b0);
    @(negedge clock);
    chk_idle("full_after", 2'd2);
    @(negedge clock);
    chk_idle("full_idle2", 2'd2);

    // Grow tick: head only.
    start = 1'b1; grow = 1'b1; food_new = 1'b0;
    @(negedge clock);
    start = 1'b0; grow = 1'b0;
    expect_seq("grow", 1, 1, 1'b0);
    @(negedge clock);
    chk_idle("grow_after", 2'd1);

    // Start held high throughout; flags toggled mid-run must not matter.
    start = 1'b1; grow = 1'b0; food_new = 1'b0;
    @(negedge clock);
    expect_seq("held1", 0, 2, 1'b1);
    @(negedge clock);
    chk_idle("held_gap", 2'd1);
    @(negedge clock);
    // Second acceptance sampled grow=1, food_new=1.
    expect_seq("held2", 1, 2, 1'b0);
    start = 1'b0;
    @(negedge clock);
    chk_idle("held_after", 2'd2);

    // Back-to-back: pulse start in the first IDLE cycle after done.
    start = 1'b1; grow = 1'b0; food_new = 1'b0;
    @(negedge clock);
    start = 1'b0;
    expect_seq("b2b_a", 0, 2, 1'b0);
    @(negedge clock);
    chk_idle("b2b_gap", 2'd1);
    start = 1'b1; grow = 1'b1; food_new = 1'b1;
    @(negedge clock);
    start = 1'b0; grow = 1'b0; food_new = 1'b0;
    expect_seq("b2b_b", 1, 2, 1'b0);
    @(negedge clock);
    chk_idle("b2b_after", 2'd2);

    // Asynchronous reset in HEAD at y_off = 2.
    start = 1'b1; grow = 1'b1; food_new = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    chk("rst_mid.pre_sel", sel, 2'd1);
    chk("rst_mid.pre_y",   y_off, 2'd2);
    chk("rst_mid.pre_x",   x_off, 2'd0);
    chk("rst_mid.pre_plot", plot, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chk_idle("rst_async", 2'd0);
    @(negedge clock);
    resetn = 1'b1; grow = 1'b0; food_new = 1'b0;
    @(negedge clock);
    chk_idle("rst_release", 2'd0);
    @(negedge clock);
    chk_idle("rst_stay_idle", 2'd0);

    // Latched food flag must not survive reset: head-only run expected.
    start = 1'b1; grow = 1'b1; food_new = 1'b0;
    @(negedge clock);
    start = 1'b0; grow = 1'b0;
    expect_seq("post_rst", 1, 1, 1'b0);
    @(negedge clock);
    chk_idle("post_rst_after", 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
